// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment display blocks: glyph table, blank
// pattern and sequence-checker state encoding.
package seven_segment_pkg;

  // Segment order is {A,B,C,D,E,F,G}; a 1 means the segment is lit.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Entry i is the glyph for hex digit i.
  localparam logic [15:0][6:0] GLYPHS = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // D
    7'b1001110,  // C
    7'b0011111,  // B
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  // Sequence checker states.
  localparam logic [0:0] ST_NO_REF   = 1'b0;
  localparam logic [0:0] ST_HAVE_REF = 1'b1;

  // Returns {hit, value}; hit is 0 when the pattern is not a hex glyph.
  function automatic logic [4:0] glyph_lookup(input logic [6:0] pat);
    logic [4:0] res;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      if (GLYPHS[i] == pat) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_debounce.sv
// Synchronizer plus debounce for a bus of asynchronous lines. A new value is
// accepted only after STABLE_CYCLES identical synchronized samples, and
// changed pulses for one cycle when the accepted value is (re)loaded.
module seg_debounce #(
  parameter int unsigned WIDTH         = 7,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             changed
);

  localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0]       sync_q [SYNC_STAGES];
  // Tracks which sync stages hold real post-reset samples, so the zeros
  // left by reset are never counted as stable input.
  logic [SYNC_STAGES-1:0] sync_vld_q;

  logic [WIDTH-1:0] cand_q, cand_d;
  logic             cand_vld_q, cand_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q;
  logic             acc_vld_q;
  logic             changed_q;
  logic             accept;

  logic [WIDTH-1:0] sample;
  logic             sample_vld;

  assign sample     = sync_q[SYNC_STAGES-1];
  assign sample_vld = sync_vld_q[SYNC_STAGES-1];

  // Synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sync_vld_q <= '0;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Candidate tracking, stability count and acceptance decision.
  always_comb begin
    cand_d     = cand_q;
    cand_vld_d = cand_vld_q;
    cnt_d      = cnt_q;
    if (sample_vld) begin
      if (!cand_vld_q || sample != cand_q) begin
        cand_d     = sample;
        cand_vld_d = 1'b1;
        cnt_d      = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Accept only on the cycle the count arrives at the limit; the first
    // acceptance after reset fires even if it matches the cleared value.
    accept = cand_vld_q && (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX) &&
             (!acc_vld_q || cand_q != acc_q);
  end

  // Debounce state and accepted value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q     <= '0;
      cand_vld_q <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      acc_vld_q  <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      cand_q     <= cand_d;
      cand_vld_q <= cand_vld_d;
      cnt_q      <= cnt_d;
      changed_q  <= accept;
      if (accept) begin
        acc_q     <= cand_q;
        acc_vld_q <= 1'b1;
      end
    end
  end

  assign dout    = acc_q;
  assign changed = changed_q;

endmodule

// File: rtl/seven_segment_decoder.sv
// Decodes a debounced seven-segment pattern into a hex digit with status
// flags, and checks that accepted digits count down by one (mod 16).
module seven_segment_decoder
  import seven_segment_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1_000_000,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_in,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             blank,
  output logic             invalid_code,
  output logic             new_code,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count
);

  logic [6:0] acc_pat;
  logic       acc_new;

  seg_debounce #(
    .WIDTH        (7),
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .din    (seg_in),
    .dout   (acc_pat),
    .changed(acc_new)
  );

  logic             glyph_hit;
  logic [3:0]       glyph_val;
  logic [3:0]       digit_q, digit_d;
  logic             valid_q, valid_d;
  logic             blank_q, blank_d;
  logic             inv_q, inv_d;
  logic             seq_err_q, seq_err_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [0:0]       state_q, state_d;
  logic [3:0]       ref_q, ref_d;

  // Classify the accepted pattern and run the descending-sequence checker.
  always_comb begin
    {glyph_hit, glyph_val} = glyph_lookup(acc_pat);
    digit_d   = digit_q;
    valid_d   = valid_q;
    blank_d   = blank_q;
    inv_d     = inv_q;
    seq_err_d = 1'b0;
    err_d     = err_q;
    state_d   = state_q;
    ref_d     = ref_q;
    if (acc_new) begin
      blank_d = (acc_pat == SEG_BLANK);
      valid_d = glyph_hit;
      inv_d   = !glyph_hit && (acc_pat != SEG_BLANK);
      if (glyph_hit) begin
        digit_d = glyph_val;
        ref_d   = glyph_val;
        state_d = ST_HAVE_REF;
        // 4-bit subtraction wraps, so 0 -> F is the legal successor.
        if (state_q == ST_HAVE_REF && glyph_val != ref_q - 4'd1) begin
          seq_err_d = 1'b1;
          if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
        end
      end else begin
        state_d = ST_NO_REF;
      end
    end
  end

  // Output registers and checker state.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q   <= '0;
      valid_q   <= 1'b0;
      blank_q   <= 1'b0;
      inv_q     <= 1'b0;
      seq_err_q <= 1'b0;
      err_q     <= '0;
      state_q   <= ST_NO_REF;
      ref_q     <= '0;
    end else begin
      digit_q   <= digit_d;
      valid_q   <= valid_d;
      blank_q   <= blank_d;
      inv_q     <= inv_d;
      seq_err_q <= seq_err_d;
      err_q     <= err_d;
      state_q   <= state_d;
      ref_q     <= ref_d;
    end
  end

  assign digit        = digit_q;
  assign digit_valid  = valid_q;
  assign blank        = blank_q;
  assign invalid_code = inv_q;
  assign new_code     = acc_new;
  assign seq_err      = seq_err_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Bench for seven_segment_decoder with SYNC_STAGES=2, STABLE_CYCLES=4, ERR_W=2.
module tb_seven_segment_decoder;

  localparam int S       = 2;
  localparam int ST      = 4;
  localparam int ERR_MAX = 3;

  logic       clk;
  logic       rst;
  logic [6:0] seg_in;
  logic [3:0] digit;
  logic       digit_valid, blank, invalid_code, new_code, seq_err;
  logic [1:0] err_count;

  seven_segment_decoder #(
    .SYNC_STAGES  (S),
    .STABLE_CYCLES(ST),
    .ERR_W        (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .digit       (digit),
    .digit_valid (digit_valid),
    .blank       (blank),
    .invalid_code(invalid_code),
    .new_code    (new_code),
    .seq_err     (seq_err),
    .err_count   (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  logic [6:0] glyph_tbl [16];

  typedef struct {
    logic [6:0] pat;
    int         dig;
    int         vld;
    int         blk;
    int         inv;
  } vec_t;
  vec_t vecs [20];

  // Reference model state.
  logic [6:0] hist [$];
  logic [6:0] m_acc;
  bit         m_acc_ok;
  bit         m_have;
  int         m_ref;
  int         e_new, e_dig, e_vld, e_blk, e_inv, e_seq, e_err;

  // Tallies of DUT pulses for directed sequences.
  int n_new, n_seq, n_inv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int glyph_of(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (glyph_tbl[i] == p) return i;
    return -1;
  endfunction

  // One rising edge of the specified behaviour: pattern accepted once it has
  // been seen ST times in a row, S edges late; flags follow one edge later.
  task automatic model_edge(input logic [6:0] s, input logic r);
    int g;
    int n;
    bit same;
    logic [6:0] p;
    if (r) begin
      hist.delete();
      e_new = 0; e_dig = 0; e_vld = 0; e_blk = 0; e_inv = 0; e_seq = 0; e_err = 0;
      m_acc = '0; m_acc_ok = 0; m_have = 0; m_ref = 0;
      return;
    end
    e_seq = 0;
    if (e_new != 0) begin
      g     = glyph_of(m_acc);
      e_blk = (m_acc == 7'd0);
      e_vld = (g >= 0);
      e_inv = (g < 0 && m_acc != 7'd0);
      if (g >= 0) begin
        e_dig = g;
        if (m_have && g != (m_ref + 15) % 16) begin
          e_seq = 1;
          if (e_err < ERR_MAX) e_err++;
        end
        m_ref  = g;
        m_have = 1;
      end else begin
        m_have = 0;
      end
    end
    e_new = 0;
    hist.push_back(s);
    if (hist.size() > S + ST) void'(hist.pop_front());
    n = hist.size();
    if (n == S + ST) begin
      p    = hist[n-1-S];
      same = 1;
      for (int j = 0; j < ST; j++) if (hist[n-1-S-j] != p) same = 0;
      if (same && (!m_acc_ok || p != m_acc)) begin
        m_acc    = p;
        m_acc_ok = 1;
        e_new    = 1;
      end
    end
  endtask

  task automatic step(input logic [6:0] pat, input logic r);
    @(negedge clk);
    seg_in = pat;
    rst    = r;
    @(posedge clk);
    model_edge(pat, r);
    #1;
    chk("new_code", new_code, e_new);
    chk("digit", digit, e_dig);
    chk("digit_valid", digit_valid, e_vld);
    chk("blank", blank, e_blk);
    chk("invalid_code", invalid_code, e_inv);
    chk("seq_err", seq_err, e_seq);
    chk("err_count", err_count, e_err);
    if (new_code) n_new++;
    if (seq_err) n_seq++;
    if (invalid_code) n_inv++;
  endtask

  task automatic hold(input logic [6:0] pat, input int cycles);
    for (int i = 0; i < cycles; i++) step(pat, 1'b0);
  endtask

  task automatic do_reset();
    step(7'd0, 1'b1);
    step(7'd0, 1'b1);
    n_new = 0; n_seq = 0; n_inv = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_digit"}, digit, 0);
    chk({tag, "_digit_valid"}, digit_valid, 0);
    chk({tag, "_blank"}, blank, 0);
    chk({tag, "_invalid"}, invalid_code, 0);
    chk({tag, "_new_code"}, new_code, 0);
    chk({tag, "_seq_err"}, seq_err, 0);
    chk({tag, "_err_count"}, err_count, 0);
  endtask

  // Edges from the first sampling edge to new_code; -1 if it never comes.
  task automatic measure_latency(input logic [6:0] pat, output int lat);
    lat = -1;
    for (int e = 0; e < 20; e++) begin
      step(pat, 1'b0);
      if (new_code) begin
        lat = e;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int r;
    int len;
    logic [6:0] pat;
    bit rflag;

    glyph_tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                  7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                  7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                  7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    for (int i = 0; i < 16; i++) vecs[i] = '{glyph_tbl[i], i, 1, 0, 0};
    vecs[16] = '{7'b0000000, 15, 0, 1, 0};
    vecs[17] = '{7'b1010101, 15, 0, 0, 1};
    vecs[18] = '{7'b0000001, 15, 0, 0, 1};
    vecs[19] = '{7'b1111111, 8, 1, 0, 0};

    seg_in = '0;
    rst    = 1'b1;
    model_edge(7'd0, 1'b1);

    // Reset state.
    do_reset();
    chk_all_zero("reset");

    // Held F from release: new_code 5 edges after the first sampling edge.
    measure_latency(7'b1000111, lat);
    chk("latency_F", lat, 5);
    step(7'b1000111, 1'b0);
    chk("first_digit", digit, 15);
    chk("first_valid", digit_valid, 1);

    // Table-driven glyph / blank / invalid decode.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      hold(vecs[i].pat, 10);
      chk("vec_digit", digit, vecs[i].dig);
      chk("vec_valid", digit_valid, vecs[i].vld);
      chk("vec_blank", blank, vecs[i].blk);
      chk("vec_invalid", invalid_code, vecs[i].inv);
    end

    // Full descending run with wrap: F..0,F.
    do_reset();
    for (int i = 15; i >= 0; i--) hold(glyph_tbl[i], 10);
    hold(glyph_tbl[15], 10);
    chk("desc_new_pulses", n_new, 17);
    chk("desc_seq_err", n_seq, 0);
    chk("desc_err_count", err_count, 0);

    // Short glitch is rejected.
    do_reset();
    hold(glyph_tbl[0], 12);
    n_new = 0;
    hold(glyph_tbl[1], 2);
    hold(glyph_tbl[0], 12);
    chk("glitch_new_pulses", n_new, 0);
    chk("glitch_digit", digit, 0);

    // 5, 7 breaks the sequence; 6 follows 7 legally.
    do_reset();
    hold(glyph_tbl[5], 10);
    hold(glyph_tbl[7], 10);
    chk("break_seq_pulses", n_seq, 1);
    chk("break_err_count", err_count, 1);
    hold(glyph_tbl[6], 10);
    chk("follow_seq_pulses", n_seq, 1);

    // Invalid pattern drops the reference; 9 then starts a new one.
    do_reset();
    hold(glyph_tbl[3], 10);
    hold(7'b1010101, 10);
    chk("inv_seen", n_inv > 0, 1);
    hold(glyph_tbl[9], 10);
    hold(glyph_tbl[8], 10);
    chk("inv_then_9_8_seq", n_seq, 0);
    do_reset();
    hold(glyph_tbl[3], 10);
    hold(7'b1010101, 10);
    hold(glyph_tbl[9], 10);
    hold(glyph_tbl[2], 10);
    chk("ref9_then_2_seq", n_seq, 1);

    // Saturation after five breaks, then reset mid-debounce.
    do_reset();
    hold(glyph_tbl[0], 10);
    for (int i = 0; i < 5; i++) hold(glyph_tbl[(i % 2 == 0) ? 5 : 0], 10);
    chk("sat_seq_pulses", n_seq, 5);
    chk("sat_err_count", err_count, 3);
    hold(glyph_tbl[7], 3);
    step(glyph_tbl[7], 1'b1);
    chk_all_zero("mid_reset");
    measure_latency(7'b0000000, lat);
    chk("latency_blank", lat, 5);
    step(7'b0000000, 1'b0);
    chk("post_reset_blank", blank, 1);
    chk("post_reset_valid", digit_valid, 0);

    // Random stimulus against the model, biased toward descending runs.
    do_reset();
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) pat = glyph_tbl[(m_ref + 15) % 16];
      else if (r < 7) pat = glyph_tbl[$urandom_range(0, 15)];
      else if (r == 7) pat = 7'd0;
      else pat = 7'($urandom);
      len   = $urandom_range(1, 9);
      rflag = ($urandom_range(0, 24) == 0);
      for (int j = 0; j < len; j++) step(pat, rflag && j == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
